// File: rtl/ahb_sram_completer.sv
// ahb_sram_completer: AHB completer over a word-organised SRAM, zero-wait OKAY and two-cycle ERROR.
// Optional wait states per data phase when AHB_SRAM_COMPLETER_WAIT_EN is defined.
module ahb_sram_completer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 1,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [STRB_WIDTH-1:0] hwstrb,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);
  localparam int SW = $clog2(STRB_WIDTH);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
  typedef enum logic [2:0] {
    IDLE, DATA, ERR1, ERR2
`ifdef AHB_SRAM_COMPLETER_WAIT_EN
    , WAIT
`endif
  } state_t;
`ifdef AHB_SRAM_COMPLETER_WAIT_EN
  localparam state_t FIRST = WAIT;
  logic [3:0] cnt;
`else
  localparam state_t FIRST = DATA;
`endif
  state_t state, nxt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IW-1:0] idx;
  logic [SW-1:0] lo;
  logic [2:0] size;
  logic write;
  logic accept, legal;
  logic [ADDR_WIDTH-1:0] off;
  logic [STRB_WIDTH-1:0] lanes;
  assign accept = hsel & htrans[1] & hready;
  assign off = haddr - BASE_ADDR;
  assign legal = haddr >= BASE_ADDR && {1'b0, off} < SPAN &&
                 (haddr & ~({ADDR_WIDTH{1'b1}} << hsize)) == '0 && hsize <= 3'(SW);
  // only the bytes covered by the registered size and offset may be written
  assign lanes = hwstrb & STRB_WIDTH'(((1 << (1 << size)) - 1) << lo);
  assign hrdata = (state == DATA && !write) ? mem[idx] : '0;
  always_comb begin
    nxt = accept ? (legal ? FIRST : ERR1) : IDLE;
    hreadyout = 1'b1;
    hresp = 1'b0;
    case (state)
      ERR1: begin
        nxt = ERR2;
        hreadyout = 1'b0;
        hresp = 1'b1;
      end
      ERR2: hresp = 1'b1;
`ifdef AHB_SRAM_COMPLETER_WAIT_EN
      WAIT: begin
        nxt = cnt == 4'd1 ? DATA : WAIT;
        hreadyout = 1'b0;
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state <= IDLE;
      idx <= '0;
      lo <= '0;
      size <= '0;
      write <= 1'b0;
`ifdef AHB_SRAM_COMPLETER_WAIT_EN
      cnt <= '0;
`endif
    end else begin
      state <= nxt;
      if (accept) begin
        idx <= off[SW +: IW];
        lo <= haddr[SW-1:0];
        size <= hsize;
        write <= hwrite;
      end
`ifdef AHB_SRAM_COMPLETER_WAIT_EN
      if (accept) cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT) cnt <= cnt - 4'd1;
`endif
    end
  end
  always_ff @(posedge hclk)
    if (!hrst && state == DATA && write)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (lanes[i]) mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
endmodule

// File: tb/tb_ahb_sram_completer.sv
// tb_ahb_sram_completer: randomized AHB master against an in-order byte-level memory model.
module tb_ahb_sram_completer;
  localparam int DEPTH = 64;
  localparam int SB = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef AHB_SRAM_COMPLETER_WAIT_EN
  localparam int WAITN = 2;
`else
  localparam int WAITN = 0;
`endif
  typedef struct {
    logic sel;
    logic [1:0] trans;
    logic [31:0] addr;
    logic wr;
    logic [2:0] size;
    logic [31:0] data;
    logic [3:0] strb;
  } xfer_t;
  typedef struct {
    logic [31:0] rdata;
    logic resp;
    int stalls;
    logic stall_resp;
  } res_t;

  logic hclk, hrst, hsel, hwrite, hready, hreadyout, hresp, ext_stall;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [3:0] hwstrb;
  xfer_t q[$];
  res_t r[$];
  logic [31:0] ref_mem [DEPTH];
  int checks, errors, run_cycles;

  assign hready = ext_stall ? 1'b0 : hreadyout;

  ahb_sram_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)
  ) dut (
    .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic xfer_t mk(logic wr, logic [31:0] a, logic [2:0] s, logic [31:0] d, logic [3:0] st);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'd2; x.addr = a; x.wr = wr; x.size = s; x.data = d; x.strb = st;
    return x;
  endfunction

  function automatic logic ref_legal(logic [31:0] a, logic [2:0] s);
    int bytes = 1 << s;
    return a >= BASE && a < BASE + DEPTH * SB && a % bytes == 0 && bytes <= SB;
  endfunction

  // expected data-phase response of one selected transfer; applies writes to the model
  function automatic res_t ref_step(xfer_t x);
    res_t e;
    int w, lo;
    e.rdata = 0; e.resp = 0; e.stalls = WAITN; e.stall_resp = 0;
    if (!ref_legal(x.addr, x.size)) begin
      e.resp = 1; e.stalls = 1; e.stall_resp = 1;
      return e;
    end
    w = int'((x.addr - BASE) / SB);
    lo = int'(x.addr % SB);
    if (x.wr) begin
      for (int b = 0; b < SB; b++)
        if (b >= lo && b < lo + (1 << x.size) && x.strb[b]) ref_mem[w][8*b +: 8] = x.data[8*b +: 8];
    end else e.rdata = ref_mem[w];
    return e;
  endfunction

  task automatic drive_addr(xfer_t x);
    hsel = x.sel; htrans = x.trans; haddr = x.addr; hwrite = x.wr; hsize = x.size;
  endtask

  // pipelined master: plays q, collects one result per selected transfer into r
  task automatic run(int nexp);
    xfer_t ap, dp;
    logic ap_v, dp_v, rdy, sr;
    int st;
    res_t t;
    r.delete();
    dp_v = 0; st = 0; sr = 0; run_cycles = 0;
    ap = q.pop_front();
    ap_v = ap.sel & ap.trans[1];
    drive_addr(ap);
    while (run_cycles < 5000 && (ap_v || dp_v || q.size() > 0)) begin
      @(negedge hclk);
      rdy = hready;
      if (dp_v) begin
        if (rdy) begin
          t.rdata = hrdata; t.resp = hresp; t.stalls = st; t.stall_resp = sr;
          r.push_back(t);
          dp_v = 0;
        end else begin
          st++;
          sr |= hresp;
        end
      end
      @(posedge hclk);
      #1;
      if (rdy) begin
        if (ap_v) begin
          dp = ap; dp_v = 1; st = 0; sr = 0;
          hwdata = dp.data; hwstrb = dp.strb;
        end
        if (q.size() > 0) ap = q.pop_front();
        else ap = '{default: 0};
        ap_v = ap.sel & ap.trans[1];
        drive_addr(ap);
      end
      run_cycles++;
    end
    drive_addr('{default: 0});
    q.delete();
    checks++;
    if (run_cycles >= 5000 || r.size() != nexp) begin
      errors++;
      $display("FAIL run_complete got %0d results in %0d cycles want %0d", r.size(), run_cycles, nexp);
    end
  endtask

  task automatic test_reset();
    hrst = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    checks++;
    if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b want 1", hreadyout); end
    checks++;
    if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b want 0", hresp); end
    checks++;
    if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", hrdata); end
    hrst = 1'b0;
  endtask

  task automatic test_fill();
    res_t e[$];
    for (int w = 0; w < DEPTH; w++) begin
      q.push_back(mk(1, BASE + 32'(w * 4), 2, $urandom, 4'hF));
      if (w > 0) q[w].trans = 2'd3;
    end
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(DEPTH);
    foreach (e[i]) begin
      checks++;
      if (r[i].resp !== 1'b0 || r[i].stalls != WAITN) begin
        errors++;
        $display("FAIL fill[%0d] got resp=%b stalls=%0d want resp=0 stalls=%0d", i, r[i].resp, r[i].stalls, WAITN);
      end
    end
  endtask

  task automatic test_write_read();
    res_t e[$];
    q.push_back(mk(1, BASE + 32'h10, 2, 32'hDEADBEEF, 4'hF));
    q.push_back(mk(0, BASE + 32'h10, 2, 32'h0, 4'h0));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(2);
    checks++;
    if (r[1].rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got %h want deadbeef", r[1].rdata); end
    checks++;
    if (r[0].resp !== 1'b0 || r[1].resp !== 1'b0 || r[0].stall_resp !== 1'b0 || r[1].stall_resp !== 1'b0) begin
      errors++; $display("FAIL wr_rd_resp got %b %b want 0 0", r[0].resp, r[1].resp);
    end
    checks++;
    if (r[0].stalls != WAITN || r[1].stalls != WAITN) begin
      errors++; $display("FAIL wr_rd_stalls got %0d %0d want %0d", r[0].stalls, r[1].stalls, WAITN);
    end
  endtask

  task automatic test_byte_write();
    res_t e[$];
    q.push_back(mk(1, BASE + 32'h11, 0, 32'h0000AB00, 4'h2));
    q.push_back(mk(0, BASE + 32'h10, 2, 32'h0, 4'h0));
    q.push_back(mk(1, BASE + 32'h12, 1, 32'h12345678, 4'hF));
    q.push_back(mk(0, BASE + 32'h10, 2, 32'h0, 4'h0));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(4);
    checks++;
    if (r[1].rdata !== 32'hDEADABEF) begin errors++; $display("FAIL byte_write got %h want deadabef", r[1].rdata); end
    checks++;
    if (r[3].rdata !== 32'h1234ABEF) begin errors++; $display("FAIL half_write got %h want 1234abef", r[3].rdata); end
  endtask

  task automatic test_out_of_range();
    res_t e[$];
    q.push_back(mk(1, BASE + DEPTH * 4, 2, 32'hA5A5A5A5, 4'hF));
    q.push_back(mk(0, BASE + DEPTH * 4, 2, 32'h0, 4'h0));
    q.push_back(mk(0, BASE - 4, 2, 32'h0, 4'h0));
    q.push_back(mk(0, BASE, 2, 32'h0, 4'h0));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (r[i].stalls != 1 || r[i].stall_resp !== 1'b1 || r[i].resp !== 1'b1 || r[i].rdata !== 32'h0) begin
        errors++;
        $display("FAIL oor_err[%0d] got stalls=%0d r1=%b r2=%b want 1 1 1", i, r[i].stalls, r[i].stall_resp, r[i].resp);
      end
    end
    checks++;
    if (r[3].rdata !== e[3].rdata || r[3].resp !== 1'b0) begin
      errors++; $display("FAIL oor_unchanged got %h want %h", r[3].rdata, e[3].rdata);
    end
  endtask

  task automatic test_misaligned();
    res_t e[$];
    q.push_back(mk(0, BASE + 32'h2, 2, 32'h0, 4'h0));
    q.push_back(mk(0, BASE + 32'h10, 2, 32'h0, 4'h0));
    q.push_back(mk(1, BASE + 32'h8, 3, 32'hFFFFFFFF, 4'hF));
    q.push_back(mk(0, BASE + 32'h8, 2, 32'h0, 4'h0));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(4);
    checks++;
    if (r[0].stalls != 1 || r[0].stall_resp !== 1'b1 || r[0].resp !== 1'b1) begin
      errors++; $display("FAIL misaligned got stalls=%0d r1=%b r2=%b want 1 1 1", r[0].stalls, r[0].stall_resp, r[0].resp);
    end
    checks++;
    if (r[1].resp !== 1'b0 || r[1].stalls != WAITN || r[1].rdata !== 32'h1234ABEF) begin
      errors++; $display("FAIL after_err got resp=%b data=%h want 0 1234abef", r[1].resp, r[1].rdata);
    end
    checks++;
    if (r[2].resp !== 1'b1 || r[2].stalls != 1) begin
      errors++; $display("FAIL oversize got resp=%b stalls=%0d want 1 1", r[2].resp, r[2].stalls);
    end
    checks++;
    if (r[3].rdata !== e[3].rdata) begin errors++; $display("FAIL oversize_unchanged got %h want %h", r[3].rdata, e[3].rdata); end
  endtask

  task automatic test_hready_stall();
    res_t e[$];
    ext_stall = 1'b1;
    drive_addr(mk(1, BASE + 32'h20, 2, 32'h0, 4'h0));
    hwdata = 32'h5A5A5A5A; hwstrb = 4'hF;
    repeat (3) begin
      @(negedge hclk);
      checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
        errors++; $display("FAIL stall_held got rdy=%b resp=%b want 1 0", hreadyout, hresp);
      end
    end
    @(posedge hclk);
    #1;
    drive_addr('{default: 0});
    ext_stall = 1'b0;
    @(posedge hclk);
    #1;
    q.push_back(mk(0, BASE + 32'h20, 2, 32'h0, 4'h0));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(1);
    checks++;
    if (r[0].rdata !== e[0].rdata) begin errors++; $display("FAIL stall_no_write got %h want %h", r[0].rdata, e[0].rdata); end
  endtask

  task automatic test_back_to_back();
    res_t e[$];
    for (int i = 0; i < 16; i++) q.push_back(mk(i[0], BASE + 32'h40 + 32'(i / 2 * 4), 2, $urandom, 4'hF));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(16);
    checks++;
    if (run_cycles != 16 * (1 + WAITN) + 1) begin
      errors++; $display("FAIL b2b_cycles got %0d want %0d", run_cycles, 16 * (1 + WAITN) + 1);
    end
    foreach (e[i]) begin
      checks++;
      if (r[i].rdata !== e[i].rdata || r[i].resp !== e[i].resp || r[i].stalls != e[i].stalls) begin
        errors++; $display("FAIL b2b[%0d] got %h/%b/%0d want %h/%b/%0d", i, r[i].rdata, r[i].resp, r[i].stalls, e[i].rdata, e[i].resp, e[i].stalls);
      end
    end
  endtask

  task automatic test_random();
    res_t e[$];
    xfer_t x;
    int w, lo, m, k;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 19);
      x.sel = $urandom_range(0, 9) != 0;
      x.trans = k == 0 ? 2'd0 : k == 1 ? 2'd1 : k < 10 ? 2'd2 : 2'd3;
      x.wr = 1'($urandom_range(0, 1));
      x.size = 3'($urandom_range(0, 2));
      w = $urandom_range(0, DEPTH - 1);
      lo = $urandom_range(0, 3);
      lo = lo - lo % (1 << x.size);
      x.addr = BASE + 32'(w * 4 + lo);
      m = $urandom_range(0, 15);
      if (m == 0) x.addr = x.addr + 1;
      if (m == 1) x.addr = BASE + 32'(DEPTH * 4 + w * 4);
      if (m == 2) x.size = 3'd3;
      if (m == 3) x.addr = BASE - 32'(4 + w * 4);
      x.data = $urandom;
      x.strb = 4'($urandom_range(0, 15));
      q.push_back(x);
    end
    foreach (q[i]) if (q[i].sel && q[i].trans[1]) e.push_back(ref_step(q[i]));
    run(e.size());
    foreach (e[i]) begin
      checks++;
      if (r[i].rdata !== e[i].rdata || r[i].resp !== e[i].resp || r[i].stalls != e[i].stalls || r[i].stall_resp !== e[i].stall_resp) begin
        errors++; $display("FAIL rand[%0d] got %h/%b/%0d want %h/%b/%0d", i, r[i].rdata, r[i].resp, r[i].stalls, e[i].rdata, e[i].resp, e[i].stalls);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t e[$];
    drive_addr(mk(1, BASE + 32'h30, 2, 32'h0, 4'h0));
    @(posedge hclk);
    #1;
    drive_addr('{default: 0});
    hwdata = 32'hCAFEF00D; hwstrb = 4'hF;
    hrst = 1'b1;
    @(posedge hclk);
    #1;
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs got %b %b %h want 1 0 0", hreadyout, hresp, hrdata);
    end
    hrst = 1'b0;
    q.push_back(mk(0, BASE + 32'h30, 2, 32'h0, 4'h0));
    foreach (q[i]) e.push_back(ref_step(q[i]));
    run(1);
    checks++;
    if (r[0].rdata !== e[0].rdata) begin errors++; $display("FAIL mid_reset_dropped got %h want %h", r[0].rdata, e[0].rdata); end
  endtask

  initial begin
    checks = 0; errors = 0; ext_stall = 1'b0; hrst = 1'b1;
    drive_addr('{default: 0});
    hwdata = '0; hwstrb = '0;
    test_reset();
    test_fill();
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_misaligned();
    test_hready_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
